// File: rtl/cbua8_reload_ctrl_if.sv
// Signal bundle between the reload controller and its CBUA8 counter.
// master = controller side, slave = counter/environment side.
interface cbua8_reload_ctrl_if #(
   parameter int WIDTH  = 8,
   parameter int PCNT_W = 8
);
   logic              START;
   logic              STOP;
   logic              MODE;
   logic [WIDTH-1:0]  RELOAD;
   logic [WIDTH-1:0]  Q;
   logic              CAO;
   logic              LD;
   logic [WIDTH-1:0]  D;
   logic              EN;
   logic              CAI;
   logic              TC;
   logic              BUSY;
   logic              DONE;
   logic [PCNT_W-1:0] PCNT;

   modport master (
      input  START, STOP, MODE, RELOAD, Q, CAO,
      output LD, D, EN, CAI, TC, BUSY, DONE, PCNT
   );

   modport slave (
      output START, STOP, MODE, RELOAD, Q, CAO,
      input  LD, D, EN, CAI, TC, BUSY, DONE, PCNT
   );
endinterface

// File: rtl/cbua8_reload_ctrl.sv
// Programmable-modulo timer control around an 8-bit loadable counter.
// One-shot and periodic modes, TC pulse, DONE flag, saturating PCNT.
module cbua8_reload_ctrl #(
   parameter int WIDTH  = 8,
   parameter int PCNT_W = 8
) (
   input logic                 CLK,
   input logic                 CDN,
   cbua8_reload_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  d_q, d_nx;
   logic              mode_q, mode_nx;
   logic              tc_q, tc_nx;
   logic              done_q, done_nx;
   logic [PCNT_W-1:0] pcnt_q, pcnt_nx;
   logic              run_go;

   // STOP gates the counter strobes so Q freezes on the abort cycle
   assign run_go  = (state == S_RUN) & ~bus.STOP;
   assign bus.EN  = run_go;
   assign bus.CAI = run_go;
   assign bus.LD  = ~bus.STOP &
                    ((state == S_LOAD) |
                     ((state == S_RUN) & mode_q & bus.CAO));

   assign bus.D    = d_q;
   assign bus.TC   = tc_q;
   assign bus.DONE = done_q;
   assign bus.PCNT = pcnt_q;
   assign bus.BUSY = (state == S_LOAD) | (state == S_RUN);

   always_ff @(posedge CLK or negedge CDN) begin
      if (!CDN) begin
         state  <= S_IDLE;
         d_q    <= '0;
         mode_q <= 1'b0;
         tc_q   <= 1'b0;
         done_q <= 1'b0;
         pcnt_q <= '0;
      end else begin
         state  <= state_nx;
         d_q    <= d_nx;
         mode_q <= mode_nx;
         tc_q   <= tc_nx;
         done_q <= done_nx;
         pcnt_q <= pcnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      d_nx     = d_q;
      mode_nx  = mode_q;
      tc_nx    = 1'b0;
      done_nx  = done_q;
      pcnt_nx  = pcnt_q;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (bus.START && !bus.STOP) begin
               state_nx = S_LOAD;
               d_nx     = bus.RELOAD;
               mode_nx  = bus.MODE;
               done_nx  = 1'b0;
               pcnt_nx  = '0;
            end
         end
         S_LOAD: begin
            state_nx = bus.STOP ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (bus.STOP) begin
               state_nx = S_IDLE;
            end else if (bus.CAO) begin
               tc_nx = 1'b1;
               if (pcnt_q != '1)
                  pcnt_nx = pcnt_q + PCNT_W'(1);
               if (!mode_q) begin
                  state_nx = S_DONE;
                  done_nx  = 1'b1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // The decision uses CAO alone; Q is only cross-checked here
   a_cao_at_top : assert property (
      @(posedge CLK) disable iff (!CDN)
      ((state == S_RUN) && bus.CAO) |-> (bus.Q == '1)
   );

endmodule

// File: tb/tb_cbua8_reload_ctrl.sv
// Bench: reload controller plus a behavioural CBUA8 counter,
// checked against an arithmetic timer model.
module tb_cbua8_reload_ctrl;

   logic clk = 1'b0;
   logic cdn = 1'b0;
   always #5 clk = ~clk;

   cbua8_reload_ctrl_if #(.WIDTH(8), .PCNT_W(8)) bus ();

   cbua8_reload_ctrl #(.WIDTH(8), .PCNT_W(8)) dut (
      .CLK (clk),
      .CDN (cdn),
      .bus (bus.master)
   );

   // attached counter: load beats count, count needs EN&CAI
   logic [7:0] q_cnt = '0;
   assign bus.Q   = q_cnt;
   assign bus.CAO = bus.EN & bus.CAI & (q_cnt == 8'hFF);
   always_ff @(posedge clk) begin
      if (bus.LD)
         q_cnt <= bus.D;
      else if (bus.EN && bus.CAI)
         q_cnt <= q_cnt + 8'd1;
   end

   int checks = 0;
   int errors = 0;

   bit         m_load = 0;
   bit         m_run  = 0;
   bit         m_done = 0;
   bit         m_mode = 0;
   bit         m_tc   = 0;
   int         m_pcnt = 0;
   int         m_k    = 0;
   logic [7:0] m_rel  = '0;
   logic [7:0] m_q    = '0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   // one clock: drive, check at negedge, advance model, take edge
   task automatic cyc(input bit st, input bit sp,
                      input bit md, input logic [7:0] rl);
      int p;
      bit wrap;
      bus.START  = st;
      bus.STOP   = sp;
      bus.MODE   = md;
      bus.RELOAD = rl;
      @(negedge clk);
      p    = 256 - int'(m_rel);
      wrap = m_run && !sp && ((m_k % p) == p - 1);
      chk("busy", 32'(bus.BUSY), 32'(m_load | m_run));
      chk("en",   32'(bus.EN),   32'(m_run && !sp));
      chk("cai",  32'(bus.CAI),  32'(m_run && !sp));
      chk("ld",   32'(bus.LD),
          32'((m_load && !sp) || (wrap && m_mode)));
      chk("d",    32'(bus.D),    32'(m_rel));
      chk("tc",   32'(bus.TC),   32'(m_tc));
      chk("done", 32'(bus.DONE), 32'(m_done));
      chk("pcnt", 32'(bus.PCNT), 32'(m_pcnt));
      chk("q",    32'(bus.Q),    32'(m_q));
      m_tc = 0;
      if (!m_load && !m_run) begin
         if (st && !sp) begin
            m_load = 1;
            m_rel  = rl;
            m_mode = md;
            m_done = 0;
            m_pcnt = 0;
         end
      end else if (m_load) begin
         m_load = 0;
         if (!sp) begin
            m_run = 1;
            m_k   = 0;
            m_q   = m_rel;
         end
      end else if (sp) begin
         m_run = 0;
      end else begin
         m_k++;
         if (wrap) begin
            m_tc   = 1;
            m_pcnt = (m_pcnt < 255) ? m_pcnt + 1 : 255;
            if (m_mode) begin
               m_q = m_rel;
            end else begin
               m_run  = 0;
               m_done = 1;
               m_q    = 8'h00;
            end
         end else begin
            m_q = m_q + 8'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(0, 0, 0, 8'h00);
   endtask

   // noise on MODE/RELOAD while busy must not matter
   task automatic noisy(input int n);
      for (int i = 0; i < n; i++)
         cyc(0, 0, 1'($urandom), 8'($urandom));
   endtask

   task automatic reset_midrun();
      #2 cdn = 1'b0;
      #1;
      chk("rst_ld",   32'(bus.LD),   0);
      chk("rst_en",   32'(bus.EN),   0);
      chk("rst_cai",  32'(bus.CAI),  0);
      chk("rst_tc",   32'(bus.TC),   0);
      chk("rst_done", 32'(bus.DONE), 0);
      chk("rst_busy", 32'(bus.BUSY), 0);
      chk("rst_pcnt", 32'(bus.PCNT), 0);
      chk("rst_q",    32'(bus.Q),    32'(m_q));
      m_load = 0;
      m_run  = 0;
      m_done = 0;
      m_mode = 0;
      m_tc   = 0;
      m_pcnt = 0;
      m_rel  = '0;
      bus.START = 0;
      bus.STOP  = 0;
      @(posedge clk);
      @(negedge clk);
      cdn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.START  = 0;
      bus.STOP   = 0;
      bus.MODE   = 0;
      bus.RELOAD = '0;
      #12;
      chk("init_busy", 32'(bus.BUSY), 0);
      chk("init_d",    32'(bus.D),    0);
      chk("init_pcnt", 32'(bus.PCNT), 0);
      chk("init_done", 32'(bus.DONE), 0);
      chk("init_ld",   32'(bus.LD),   0);
      #5 cdn = 1'b1;
      @(posedge clk);
      #1;

      cyc(1, 0, 0, 8'hFC);
      noisy(5);
      idle(6);

      cyc(1, 0, 1, 8'hFD);
      noisy(13);
      cyc(0, 1, 0, 8'h00);
      idle(2);

      cyc(1, 0, 1, 8'hFF);
      noisy(300);
      cyc(0, 1, 0, 8'h00);
      idle(2);

      cyc(1, 0, 1, 8'hFE);
      idle(2);
      cyc(0, 1, 0, 8'h00);
      idle(3);

      cyc(1, 0, 1, 8'hF8);
      idle(4);
      cyc(1, 0, 0, 8'h10);
      idle(3);
      cyc(0, 1, 0, 8'h00);
      cyc(1, 1, 1, 8'h33);
      idle(3);

      cyc(1, 0, 1, 8'hF0);
      idle(6);
      reset_midrun();
      idle(3);

      for (int i = 0; i < 4000; i++) begin
         bit         st, sp, md;
         logic [7:0] rl;
         st = ($urandom % 10) == 0;
         sp = ($urandom % 50) == 0;
         md = 1'($urandom);
         if (($urandom % 8) == 0)
            rl = 8'($urandom);
         else
            rl = 8'hF0 | 8'($urandom % 16);
         cyc(st, sp, md, rl);
      end

      cyc(1, 0, 1, 8'hF4);
      idle(9);
      reset_midrun();
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
